even_parity_serial_tx: RTL and testbench
========================================

// Module: even_parity_serial_tx
//
// PURPOSE
//   Transmit end of the even-parity link.
//   - Accepts a parallel word on a valid/ready handshake and computes its even parity bit.
//   - Shifts the frame out serially: start, data LSB-first, parity, stop.
//   - The downstream receiver recomputes parity and flags an error on mismatch.
//   - Paired with even_parity_check in link-level benches.
//
// PARAMETERS
//   DATA_W    4   data word width in bits (>=1)
//   BAUD_DIV  4   clock cycles each serial bit is held (>=1; 1 = one bit per clock)
//
// PORTS
//   clk         in   1        system clock, rising edge
//   rst_n       in   1        asynchronous active-low reset
//   in_data     in   DATA_W   word to transmit; sampled only on acceptance
//   in_valid    in   1        word available
//   in_ready    out  1        block can accept; high only in IDLE
//   tx_out      out  1        serial line; idles high
//   tx_busy     out  1        frame in progress (START..STOP)
//   parity_out  out  1        even parity bit of the frame in flight (^in_data at accept)
//   frame_done  out  1        one-cycle pulse on the last cycle of the stop bit
//
// BEHAVIOUR
//   - All outputs registered. Reset values: tx_out=1, in_ready=1, tx_busy=0, parity_out=0,
//     frame_done=0, FSM=IDLE, baud counter=0, bit index=0.
//   - FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//   - Acceptance: in_valid && in_ready at a rising edge while in IDLE.
//     - Latch in_data into the shift register.
//     - parity_out <= ^in_data, which makes the total count of 1s over data+parity even.
//     - Next state is START; in_ready and tx_busy change on the same edge.
//   - START: tx_out=0 for BAUD_DIV cycles.
//   - DATA: tx_out = data[i] for i = 0..DATA_W-1, each held BAUD_DIV cycles.
//   - PARITY: tx_out = parity_out for BAUD_DIV cycles.
//   - STOP: tx_out=1 for BAUD_DIV cycles. frame_done=1 on its final cycle.
//   - Return to IDLE: in_ready=1 and tx_busy=0 on the following cycle.
//   - Timing:
//     - Frame length (DATA_W+3)*BAUD_DIV cycles, from the first start-bit cycle to the last stop-bit cycle.
//     - Minimum gap between frames is one IDLE cycle with tx_out=1, even with in_valid held high.
//   - Baud counter counts 0..BAUD_DIV-1 and wraps. State/bit-index advances when counter==BAUD_DIV-1.
//     - BAUD_DIV=1: one state/bit per clock.
//   - No queuing while busy:
//     - in_valid is ignored outside IDLE.
//     - in_data changes after acceptance do not affect the frame in flight.
//   - parity_out holds its value after the frame until the next acceptance.
//   - Reset asserted mid-frame:
//     - tx_out goes to 1 asynchronously and the frame is discarded.
//     - No frame_done pulse is produced.
//     - The first frame after release behaves normally.
//   - Bit index and counter widths are sized by $clog2 with a minimum of 1 bit.
//     - No overflow for any legal parameter value.
//
// CONFIGURATION
//   PARITY_ERR_INJECT_EN (macro)
//   - Defined:
//     - Adds input port err_inject (1 bit), sampled at acceptance.
//     - If err_inject=1, parity_out <= ~(^in_data), so the downstream checker must flag an error.
//     - err_inject is ignored at all other times.
//   - Undefined:
//     - No err_inject port.
//     - parity_out is always ^in_data.
//
// TESTING  (DATA_W=4, BAUD_DIV=4 unless noted)
//   1. Hold rst_n=0 -> tx_out=1, in_ready=1, tx_busy=0, frame_done=0.
//      Release reset, in_valid=0 -> line stays 1.
//   2. Accept 4'b1010 -> parity_out=0. tx_out sequence 0,0,1,0,1,0,1, each for 4 cycles.
//      frame_done pulses on cycle 28 of the frame; in_ready=1 the next cycle.
//   3. Accept 4'b0111 -> parity_out=1. Deserialize into even_parity_check -> error=0.
//      Repeat for all 16 data values: error=0.
//   4. Hold in_valid=1 with 4'b0001 then 4'b1111 -> two frames separated by exactly one IDLE cycle.
//      Parity bits are 1 then 0.
//   5. Pulse rst_n low during the 2nd data bit -> tx_out=1 immediately, no frame_done.
//      Next accept of 4'b1100 yields a correct 28-cycle frame.
//   6. With PARITY_ERR_INJECT_EN, err_inject=1, 4'b1010 -> parity bit 1, checker error=1.
//      Repeat with BAUD_DIV=1 -> frame length 7 cycles.

Source files
------------

// File: rtl/even_parity_serial_tx.sv
// Even-parity serial transmitter: start, DATA_W data bits LSB-first, parity, stop.
// Latency: the first start-bit cycle follows the accepting edge; a frame lasts (DATA_W+3)*BAUD_DIV cycles.
// Backpressure: in_ready is high only in IDLE. Optional PARITY_ERR_INJECT_EN adds err_inject to flip the parity bit.
module even_parity_serial_tx #(
  parameter int DATA_W   = 4,
  parameter int BAUD_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              parity_out,
  output logic              frame_done
`ifdef PARITY_ERR_INJECT_EN
  ,
  input  logic              err_inject
`endif
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_d, rdy_d, busy_d, par_d, done_d;
  logic              bit_end;
  logic              new_par;

`ifdef PARITY_ERR_INJECT_EN
  assign new_par = (^in_data) ^ err_inject;
`else
  assign new_par = ^in_data;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_out;
    rdy_d   = in_ready;
    busy_d  = tx_busy;
    par_d   = parity_out;
    bit_end = (cnt_q == CNT_LAST);
    cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (in_valid && in_ready) begin
          shreg_d = in_data;
          par_d   = new_par;
          idx_d   = '0;
          state_d = S_START;
          tx_d    = 1'b0;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_PARITY;
            tx_d    = parity_out;
          end else begin
            // Shift so the next data bit always sits at bit 0.
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_d[0];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          idx_d   = '0;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Registered pulse lands on the last cycle of the stop bit.
    done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      tx_out     <= 1'b1;
      in_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      parity_out <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      tx_out     <= tx_d;
      in_ready   <= rdy_d;
      tx_busy    <= busy_d;
      parity_out <= par_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Directed bench for even_parity_serial_tx: one instance at BAUD_DIV=4 and one at BAUD_DIV=1.
module tb_even_parity_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_data, in_data1;
  logic       in_valid, in_valid1;
  logic       in_ready, in_ready1;
  logic       tx_out, tx1;
  logic       tx_busy, busy1;
  logic       parity_out, par1;
  logic       frame_done, done1;
  logic       err_inj;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  even_parity_serial_tx #(.DATA_W(4), .BAUD_DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_out(tx_out), .tx_busy(tx_busy),
    .parity_out(parity_out), .frame_done(frame_done)
`ifdef PARITY_ERR_INJECT_EN
    , .err_inject(err_inj)
`endif
  );

  even_parity_serial_tx #(.DATA_W(4), .BAUD_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx_out(tx1), .tx_busy(busy1),
    .parity_out(par1), .frame_done(done1)
`ifdef PARITY_ERR_INJECT_EN
    , .err_inject(err_inj)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples one frame starting at its first start-bit cycle; leaves time at the cycle after the frame.
  task automatic capture(input int bd, output logic [6:0] bits, output int done_cyc, output logic held);
    logic s, f;
    held     = 1'b1;
    done_cyc = 0;
    bits     = '0;
    for (int k = 0; k < 7 * bd; k++) begin
      s = (bd == 1) ? tx1 : tx_out;
      f = (bd == 1) ? done1 : frame_done;
      if (k % bd == 0) bits[k / bd] = s;
      else if (s !== bits[k / bd]) held = 1'b0;
      if (f === 1'b1) done_cyc = (done_cyc == 0) ? k + 1 : -1;
      tick();
    end
  endtask

  // Receiver model: even parity over data + parity bit must be zero.
  function automatic logic rx_err(input logic [6:0] bits);
    return ^bits[5:1];
  endfunction

  task automatic send4(input logic [3:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] bits;
    int         dc;
    logic       held;
    logic       quiet;
    logic [3:0] v;

    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_data1 = '0; in_valid1 = 1'b0; err_inj = 1'b0;
    #12;
    chk("rst_tx_out", tx_out, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_parity_out", parity_out, 0);
    chk("rst_tx1", tx1, 1);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_tx_out", tx_out, 1);
    chk("idle_in_ready", in_ready, 1);

    // 1010: parity 0, line 0,0,1,0,1,0,1
    send4(4'b1010);
    chk("a1010_parity", parity_out, 0);
    chk("a1010_busy", tx_busy, 1);
    chk("a1010_ready", in_ready, 0);
    capture(4, bits, dc, held);
    chk("a1010_bits", bits, 7'b1010100);
    chk("a1010_done_cycle", dc, 28);
    chk("a1010_held", held, 1);
    chk("a1010_ready_after", in_ready, 1);
    chk("a1010_busy_after", tx_busy, 0);
    chk("a1010_done_after", frame_done, 0);

    send4(4'b0111);
    chk("a0111_parity", parity_out, 1);
    capture(4, bits, dc, held);
    chk("a0111_rx_err", rx_err(bits), 0);
    chk("a0111_bits", bits, 7'b1101110);
    chk("a0111_parity_hold", parity_out, 1);

    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      send4(v);
      chk($sformatf("sweep%0d_parity", i), parity_out, ^v);
      capture(4, bits, dc, held);
      chk($sformatf("sweep%0d_rx_err", i), rx_err(bits), 0);
      chk($sformatf("sweep%0d_bits", i), bits, {1'b1, ^v, v, 1'b0});
    end

    // in_valid held high; in_data changed mid-frame must not disturb frame 1
    in_data  = 4'b0001;
    in_valid = 1'b1;
    tick();
    in_data  = 4'b1111;
    capture(4, bits, dc, held);
    chk("b2b_f1_bits", bits, 7'b1100010);
    chk("b2b_f1_done", dc, 28);
    chk("b2b_gap_tx", tx_out, 1);
    chk("b2b_gap_ready", in_ready, 1);
    chk("b2b_gap_busy", tx_busy, 0);
    tick();
    in_valid = 1'b0;
    chk("b2b_f2_start", tx_out, 0);
    chk("b2b_f2_parity", parity_out, 0);
    capture(4, bits, dc, held);
    chk("b2b_f2_bits", bits, 7'b1011110);

    // Reset during the 2nd data bit (cycles 9..12 of the frame)
    send4(4'b0101);
    repeat (9) tick();
    chk("mid_pre_tx", tx_out, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx_out, 1);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (frame_done !== 1'b0 || tx_out !== 1'b1) quiet = 1'b0;
      tick();
    end
    chk("mid_rst_no_done", quiet, 1);
    send4(4'b1100);
    chk("post_rst_parity", parity_out, 0);
    capture(4, bits, dc, held);
    chk("post_rst_bits", bits, 7'b1011000);
    chk("post_rst_done", dc, 28);
    chk("post_rst_held", held, 1);

`ifdef PARITY_ERR_INJECT_EN
    err_inj = 1'b1;
    send4(4'b1010);
    err_inj = 1'b0;
    chk("inj_parity", parity_out, 1);
    capture(4, bits, dc, held);
    chk("inj_bits", bits, 7'b1110100);
    chk("inj_rx_err", rx_err(bits), 1);
    err_inj = 1'b1;
`endif

    // BAUD_DIV=1 instance: 7-cycle frame
    in_data1  = 4'b1010;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    err_inj   = 1'b0;
    capture(1, bits, dc, held);
`ifdef PARITY_ERR_INJECT_EN
    chk("bd1_bits", bits, 7'b1110100);
    chk("bd1_rx_err", rx_err(bits), 1);
`else
    chk("bd1_bits", bits, 7'b1010100);
    chk("bd1_rx_err", rx_err(bits), 0);
`endif
    chk("bd1_done_cycle", dc, 7);
    chk("bd1_ready_after", in_ready1, 1);
    chk("bd1_busy_after", busy1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
